cnu_min_accum: RTL and testbench

CNU_MIN_ACCUM -- requirements
Module: cnu_min_accum

---
 rtl/cnu_pkg.sv | 12 +
 rtl/cnu_min_accum_if.sv | 26 ++
 rtl/cnu_merge2.sv | 42 ++++
 rtl/cnu_min_accum.sv | 203 ++++++++++++++++++++
 tb/tb_cnu_min_accum.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cnu_pkg.sv
// rtl/cnu_pkg.sv - shared types and default widths for the check-node min accumulator
package cnu_pkg;

    localparam int CNU_DATA_W = 8;
    localparam int CNU_IDX_W  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } cnu_state_e;

endpackage

// File: rtl/cnu_min_accum_if.sv
// rtl/cnu_min_accum_if.sv - beat input and row result handshake bundle
interface cnu_min_accum_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_min;
    logic [2*IDX_W-1:0]    in_idx;
    logic                  in_sign;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_min;
    logic [2*IDX_W-1:0]    out_idx;
    logic                  out_sign;

    modport master (
        output in_valid, in_min, in_idx, in_sign, out_ready,
        input  in_ready, out_valid, out_min, out_idx, out_sign
    );

    modport slave (
        input  in_valid, in_min, in_idx, in_sign, out_ready,
        output in_ready, out_valid, out_min, out_idx, out_sign
    );
endinterface

// File: rtl/cnu_merge2.sv
// rtl/cnu_merge2.sv - combinational merge of two {min2,min1,idx2,idx1} tuples, accumulator wins ties
module cnu_merge2 #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic [DATA_W-1:0] a_min1,
    input  logic [DATA_W-1:0] a_min2,
    input  logic [IDX_W-1:0]  a_idx1,
    input  logic [IDX_W-1:0]  a_idx2,
    input  logic [DATA_W-1:0] b_min1,
    input  logic [DATA_W-1:0] b_min2,
    input  logic [IDX_W-1:0]  b_idx1,
    input  logic [IDX_W-1:0]  b_idx2,
    output logic [DATA_W-1:0] m_min1,
    output logic [DATA_W-1:0] m_min2,
    output logic [IDX_W-1:0]  m_idx1,
    output logic [IDX_W-1:0]  m_idx2
);

    // Strict less-than everywhere so that equal values keep the accumulated entry.
    always_comb begin
        m_min1 = a_min1;
        m_idx1 = a_idx1;
        m_min2 = a_min2;
        m_idx2 = a_idx2;
        if (b_min1 < a_min1) begin
            m_min1 = b_min1;
            m_idx1 = b_idx1;
            if (b_min2 < a_min1) begin
                m_min2 = b_min2;
                m_idx2 = b_idx2;
            end else begin
                m_min2 = a_min1;
                m_idx2 = a_idx1;
            end
        end else if (b_min1 < a_min2) begin
            m_min2 = b_min1;
            m_idx2 = b_idx1;
        end
    end

endmodule

// File: rtl/cnu_min_accum.sv
// rtl/cnu_min_accum.sv - row-wide two-minimum accumulator; CNU_OFFSET_EN enables offset-min output
module cnu_min_accum
    import cnu_pkg::*;
#(
    parameter int DATA_W = CNU_DATA_W,
    parameter int IDX_W  = CNU_IDX_W,
    parameter int BEATS  = 4,
    parameter int OFFSET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cnu_min_accum_if.slave  bus
);

    localparam int CNT_W = $clog2(BEATS + 1);

    if (BEATS < 2 || BEATS > 255 || OFFSET < 0) begin : g_bad_param
        $error("cnu_min_accum: BEATS must be 2..255 and OFFSET non-negative");
    end

    cnu_state_e        state_q;
    cnu_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] acc_min1_q;
    logic [DATA_W-1:0] acc_min2_q;
    logic [IDX_W-1:0]  acc_idx1_q;
    logic [IDX_W-1:0]  acc_idx2_q;
    logic              acc_sign_q;

    logic [DATA_W-1:0] res_min1_q;
    logic [DATA_W-1:0] res_min2_q;
    logic [IDX_W-1:0]  res_idx1_q;
    logic [IDX_W-1:0]  res_idx2_q;
    logic              res_sign_q;

    logic              in_ready;
    logic              out_valid;
    logic              in_fire;
    logic              out_fire;
    logic              last_beat;
    logic              first_beat;

    logic [DATA_W-1:0] b_min1;
    logic [DATA_W-1:0] b_min2;
    logic [IDX_W-1:0]  b_idx1;
    logic [IDX_W-1:0]  b_idx2;

    logic [DATA_W-1:0] m_min1;
    logic [DATA_W-1:0] m_min2;
    logic [IDX_W-1:0]  m_idx1;
    logic [IDX_W-1:0]  m_idx2;

    logic [DATA_W-1:0] nxt_min1;
    logic [DATA_W-1:0] nxt_min2;
    logic [IDX_W-1:0]  nxt_idx1;
    logic [IDX_W-1:0]  nxt_idx2;
    logic              nxt_sign;

    logic [DATA_W-1:0] adj_min1;
    logic [DATA_W-1:0] adj_min2;

    assign b_min1 = bus.in_min[DATA_W-1:0];
    assign b_min2 = bus.in_min[2*DATA_W-1:DATA_W];
    assign b_idx1 = bus.in_idx[IDX_W-1:0];
    assign b_idx2 = bus.in_idx[2*IDX_W-1:IDX_W];

    assign in_fire    = bus.in_valid & in_ready;
    assign out_fire   = out_valid & bus.out_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = in_fire && (cnt_q == CNT_W'(BEATS - 1));

    cnu_merge2 #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_merge (
        .a_min1 (acc_min1_q),
        .a_min2 (acc_min2_q),
        .a_idx1 (acc_idx1_q),
        .a_idx2 (acc_idx2_q),
        .b_min1 (b_min1),
        .b_min2 (b_min2),
        .b_idx1 (b_idx1),
        .b_idx2 (b_idx2),
        .m_min1 (m_min1),
        .m_min2 (m_min2),
        .m_idx1 (m_idx1),
        .m_idx2 (m_idx2)
    );

    // The first beat of a row bypasses the merge so stale accumulator contents never leak in.
    always_comb begin
        nxt_min1 = first_beat ? b_min1 : m_min1;
        nxt_min2 = first_beat ? b_min2 : m_min2;
        nxt_idx1 = first_beat ? b_idx1 : m_idx1;
        nxt_idx2 = first_beat ? b_idx2 : m_idx2;
        nxt_sign = first_beat ? bus.in_sign : (acc_sign_q ^ bus.in_sign);
    end

`ifdef CNU_OFFSET_EN
    localparam logic [DATA_W-1:0] OFF_V = DATA_W'(OFFSET);

    // Offset-min correction, saturating at zero.
    always_comb begin
        adj_min1 = (nxt_min1 > OFF_V) ? (nxt_min1 - OFF_V) : '0;
        adj_min2 = (nxt_min2 > OFF_V) ? (nxt_min2 - OFF_V) : '0;
    end
`else
    // Raw minima pass straight through.
    always_comb begin
        adj_min1 = nxt_min1;
        adj_min2 = nxt_min2;
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the last beat of a row enters HOLD, the output handshake returns to ACCUM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_beat) state_d = HOLD;
            HOLD:    if (out_fire)  state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Beat counter: counts accepted beats, cleared when the row result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (out_fire) begin
            cnt_q <= '0;
        end else if (in_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Accumulator update on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_min1_q <= '0;
            acc_min2_q <= '0;
            acc_idx1_q <= '0;
            acc_idx2_q <= '0;
            acc_sign_q <= 1'b0;
        end else if (in_fire) begin
            acc_min1_q <= nxt_min1;
            acc_min2_q <= nxt_min2;
            acc_idx1_q <= nxt_idx1;
            acc_idx2_q <= nxt_idx2;
            acc_sign_q <= nxt_sign;
        end
    end

    // Result register: captured with the last beat, zeroed once handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_min1_q <= '0;
            res_min2_q <= '0;
            res_idx1_q <= '0;
            res_idx2_q <= '0;
            res_sign_q <= 1'b0;
        end else if (last_beat) begin
            res_min1_q <= adj_min1;
            res_min2_q <= adj_min2;
            res_idx1_q <= nxt_idx1;
            res_idx2_q <= nxt_idx2;
            res_sign_q <= nxt_sign;
        end else if (out_fire) begin
            res_min1_q <= '0;
            res_min2_q <= '0;
            res_idx1_q <= '0;
            res_idx2_q <= '0;
            res_sign_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_min   = {res_min2_q, res_min1_q};
    assign bus.out_idx   = {res_idx2_q, res_idx1_q};
    assign bus.out_sign  = res_sign_q;

endmodule

// File: tb/tb_cnu_min_accum.sv
// tb/tb_cnu_min_accum.sv - directed self-checking bench for cnu_min_accum
module tb_cnu_min_accum;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    cnu_min_accum_if #(.DATA_W(8), .IDX_W(8)) bus ();

    cnu_min_accum #(
        .DATA_W (8),
        .IDX_W  (8),
        .BEATS  (4),
        .OFFSET (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef CNU_OFFSET_EN
    localparam logic [15:0] EXP_ROW1   = 16'h0302;
    localparam logic [15:0] EXP_TIE    = 16'h0404;
    localparam logic [15:0] EXP_BRANCH = 16'h0201;
    localparam logic [15:0] EXP_UNS    = 16'h7F0F;
`else
    localparam logic [15:0] EXP_ROW1   = 16'h0403;
    localparam logic [15:0] EXP_TIE    = 16'h0505;
    localparam logic [15:0] EXP_BRANCH = 16'h0302;
    localparam logic [15:0] EXP_UNS    = 16'h8010;
`endif

    // beat 0 in the low 16 bits
    localparam logic [63:0] ROW1_MIN   = {16'h0604, 16'h140C, 16'h0703, 16'h0905};
    localparam logic [63:0] STD_IDX    = {16'h0706, 16'h0504, 16'h0302, 16'h0100};
    localparam logic [63:0] TIE_MIN    = {16'h0909, 16'h0808, 16'h0505, 16'h0505};
    localparam logic [63:0] BRANCH_MIN = {16'h3C32, 16'h3228, 16'h0302, 16'h0908};
    localparam logic [63:0] UNS_MIN    = {16'hFFFF, 16'h8180, 16'hFE10, 16'hFFF0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] mn, input logic [15:0] ix, input logic sg);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_min   = mn;
        bus.in_idx   = ix;
        bus.in_sign  = sg;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_row(input string tag, input logic [63:0] mins,
                            input logic [63:0] idxs, input logic [3:0] sg);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            send_beat(mins[16*k +: 16], idxs[16*k +: 16], sg[k]);
        end
    endtask

    task automatic check_row(input string tag, input logic [15:0] emin,
                             input logic [15:0] eidx, input logic esign);
        chk({tag, "_valid"},    32'(bus.out_valid), 32'd1);
        chk({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
        chk({tag, "_min"},      32'(bus.out_min),   32'(emin));
        chk({tag, "_idx"},      32'(bus.out_idx),   32'(eidx));
        chk({tag, "_sign"},     32'(bus.out_sign),  32'(esign));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready),  32'd1);
        chk({tag, "_min_zero"},   32'(bus.out_min),   32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_min"},   32'(bus.out_min),   32'd0);
        chk({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
        chk({tag, "_out_sign"},  32'(bus.out_sign),  32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_min    = '0;
        bus.in_idx    = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic row, sign 1,0,1,1
        send_row("row1", ROW1_MIN, STD_IDX, 4'b1101);
        check_row("row1", EXP_ROW1, 16'h0602, 1'b1);

        // ties keep the accumulated value, sign 1,1,0,0; then hold with in_valid high
        send_row("tie", TIE_MIN, STD_IDX, 4'b0011);
        bus.in_valid = 1'b1;
        bus.in_min   = 16'h0100;
        bus.in_idx   = 16'hAABB;
        bus.in_sign  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("hold_min",      32'(bus.out_min),   32'(EXP_TIE));
            chk("hold_idx",      32'(bus.out_idx),   32'h0100);
            chk("hold_sign",     32'(bus.out_sign),  32'd0);
            chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
            chk("hold_valid",    32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("release_in_ready", 32'(bus.in_ready),  32'd1);
        chk("release_valid",    32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        // held beat must not have been consumed
        send_row("row1b", ROW1_MIN, STD_IDX, 4'b0011);
        check_row("row1b", EXP_ROW1, 16'h0602, 1'b0);

        // new beat's min2 displaces accumulated min1
        send_row("branch", BRANCH_MIN, STD_IDX, 4'b0111);
        check_row("branch", EXP_BRANCH, 16'h0302, 1'b1);

        // unsigned compare with top-bit-set magnitudes
        send_row("uns", UNS_MIN, STD_IDX, 4'b0000);
        check_row("uns", EXP_UNS, 16'h0402, 1'b0);

        // all zeros: saturation at zero when offset is on
        send_row("zero", 64'd0, STD_IDX, 4'b1000);
        check_row("zero", 16'h0000, 16'h0100, 1'b1);

        // reset after two beats of dominating zeros
        send_beat(16'h0000, 16'h1111, 1'b1);
        send_beat(16'h0000, 16'h2222, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_row("fresh", TIE_MIN, STD_IDX, 4'b0001);
        check_row("fresh", EXP_TIE, 16'h0100, 1'b1);

        // reset while holding a result
        send_row("pre_rst", ROW1_MIN, STD_IDX, 4'b1101);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_row("post", BRANCH_MIN, STD_IDX, 4'b0110);
        check_row("post", EXP_BRANCH, 16'h0302, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
